// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared constants for the memory-side request responder
package mem_ctrl_pkg;

    localparam logic [1:0]  MEM_SIZE_B       = 2'd0;
    localparam logic [1:0]  MEM_SIZE_H       = 2'd1;
    localparam logic [1:0]  MEM_SIZE_W       = 2'd2;
    localparam logic [31:0] IO_ADDR_BASE_DEF = 32'h0003_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } mem_state_e;

    // Encoding 3 is illegal and is handled as a full word.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            MEM_SIZE_B: size_bytes = 3'd1;
            MEM_SIZE_H: size_bytes = 3'd2;
            default:    size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-wide RAM sequencer for fetch and LSB requests
// Optional IO_STALL_EN: store bytes at or above IO_ADDR_BASE wait while io_buffer_full.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int          ADDR_WIDTH   = 32,
    parameter logic [31:0] IO_ADDR_BASE = IO_ADDR_BASE_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  in_fetcher_ce,
    input  logic [31:0]           in_fetcher_pc,
    output logic                  out_fetcher_ce,
    output logic [31:0]           out_fetcher_instr,
    input  logic                  in_lsb_ce,
    input  logic                  in_lsb_wr,
    input  logic [1:0]            in_lsb_size,
    input  logic [31:0]           in_lsb_addr,
    input  logic [31:0]           in_lsb_data,
    output logic                  out_lsb_ce,
    output logic [31:0]           out_lsb_data,
    input  logic                  in_rob_misbranch,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full
);

    mem_state_e            state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  f_pend_q, f_pend_d;
    logic [ADDR_WIDTH-1:0] f_addr_q, f_addr_d;
    logic                  l_pend_q, l_pend_d;
    logic                  l_wr_q, l_wr_d;
    logic [1:0]            l_size_q, l_size_d;
    logic [ADDR_WIDTH-1:0] l_addr_q, l_addr_d;
    logic [31:0]           l_data_q, l_data_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [31:0]           cur_data_q, cur_data_d;
    logic [2:0]            cur_n_q, cur_n_d;
    logic                  cur_fetch_q, cur_fetch_d;
    logic [31:0]           rbuf_q, rbuf_d;
    logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
    logic [7:0]            mem_dout_q, mem_dout_d;
    logic                  mem_wr_q, mem_wr_d;
    logic                  out_f_ce_q, out_f_ce_d;
    logic [31:0]           out_f_instr_q, out_f_instr_d;
    logic                  out_l_ce_q, out_l_ce_d;
    logic [31:0]           out_l_data_q, out_l_data_d;

    logic [ADDR_WIDTH-1:0] stall_a;
    logic                  io_stall;

    // Address of the next store byte: byte 0 of the pending store in IDLE, else the in-flight one.
    assign stall_a = (state_q == ST_IDLE) ? l_addr_q : cur_addr_q + ADDR_WIDTH'(cnt_q);

`ifdef IO_STALL_EN
    assign io_stall = io_buffer_full && (stall_a >= ADDR_WIDTH'(IO_ADDR_BASE));
`else
    logic unused_io;
    assign unused_io = &{1'b0, io_buffer_full, IO_ADDR_BASE[0], stall_a[0]};
    assign io_stall  = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        f_pend_d      = f_pend_q;
        f_addr_d      = f_addr_q;
        l_pend_d      = l_pend_q;
        l_wr_d        = l_wr_q;
        l_size_d      = l_size_q;
        l_addr_d      = l_addr_q;
        l_data_d      = l_data_q;
        cur_addr_d    = cur_addr_q;
        cur_data_d    = cur_data_q;
        cur_n_d       = cur_n_q;
        cur_fetch_d   = cur_fetch_q;
        rbuf_d        = rbuf_q;
        mem_a_d       = mem_a_q;
        mem_dout_d    = mem_dout_q;
        mem_wr_d      = mem_wr_q;
        out_f_ce_d    = 1'b0;
        out_f_instr_d = out_f_instr_q;
        out_l_ce_d    = 1'b0;
        out_l_data_d  = out_l_data_q;

        case (state_q)
            ST_IDLE: begin
                if (l_pend_q && (l_wr_q || !in_rob_misbranch)) begin
                    l_pend_d    = 1'b0;
                    cur_addr_d  = l_addr_q;
                    cur_data_d  = l_data_q;
                    cur_n_d     = size_bytes(l_size_q);
                    cur_fetch_d = 1'b0;
                    mem_a_d     = l_addr_q;
                    cnt_d       = 3'd0;
                    rbuf_d      = '0;
                    if (l_wr_q) begin
                        state_d = ST_WRITE;
                        if (!io_stall) begin
                            mem_wr_d   = 1'b1;
                            mem_dout_d = l_data_q[7:0];
                            cnt_d      = 3'd1;
                        end
                    end else begin
                        state_d = ST_READ;
                    end
                end else if (f_pend_q && !in_rob_misbranch) begin
                    f_pend_d    = 1'b0;
                    cur_addr_d  = f_addr_q;
                    cur_n_d     = 3'd4;
                    cur_fetch_d = 1'b1;
                    mem_a_d     = f_addr_q;
                    cnt_d       = 3'd0;
                    rbuf_d      = '0;
                    state_d     = ST_READ;
                end
            end
            ST_READ: begin
                if (in_rob_misbranch) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == cur_n_q) begin
                    state_d = ST_IDLE;
                    if (cur_fetch_q) begin
                        out_f_ce_d    = 1'b1;
                        out_f_instr_d = rbuf_q;
                    end else begin
                        out_l_ce_d   = 1'b1;
                        out_l_data_d = rbuf_q;
                    end
                end else begin
                    rbuf_d[{cnt_q[1:0], 3'b000} +: 8] = mem_din;
                    cnt_d = cnt_q + 3'd1;
                    if ((cnt_q + 3'd1) < cur_n_q)
                        mem_a_d = cur_addr_q + ADDR_WIDTH'(cnt_q + 3'd1);
                end
            end
            ST_WRITE: begin
                if (cnt_q == cur_n_q) begin
                    state_d      = ST_IDLE;
                    mem_wr_d     = 1'b0;
                    out_l_ce_d   = 1'b1;
                    out_l_data_d = '0;
                end else if (io_stall) begin
                    mem_wr_d = 1'b0;
                end else begin
                    mem_wr_d   = 1'b1;
                    mem_a_d    = stall_a;
                    mem_dout_d = cur_data_q[{cnt_q[1:0], 3'b000} +: 8];
                    cnt_d      = cnt_q + 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Request capture runs after the start logic so a pulse on the start edge stays pending.
        if (in_rob_misbranch) begin
            f_pend_d = 1'b0;
            if (!l_wr_q)
                l_pend_d = 1'b0;
        end
        if (in_fetcher_ce && !in_rob_misbranch) begin
            f_pend_d = 1'b1;
            f_addr_d = ADDR_WIDTH'(in_fetcher_pc);
        end
        if (in_lsb_ce && (in_lsb_wr || !in_rob_misbranch)) begin
            l_pend_d = 1'b1;
            l_wr_d   = in_lsb_wr;
            l_size_d = in_lsb_size;
            l_addr_d = ADDR_WIDTH'(in_lsb_addr);
            l_data_d = in_lsb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            f_pend_q      <= 1'b0;
            f_addr_q      <= '0;
            l_pend_q      <= 1'b0;
            l_wr_q        <= 1'b0;
            l_size_q      <= '0;
            l_addr_q      <= '0;
            l_data_q      <= '0;
            cur_addr_q    <= '0;
            cur_data_q    <= '0;
            cur_n_q       <= '0;
            cur_fetch_q   <= 1'b0;
            rbuf_q        <= '0;
            mem_a_q       <= '0;
            mem_dout_q    <= '0;
            mem_wr_q      <= 1'b0;
            out_f_ce_q    <= 1'b0;
            out_f_instr_q <= '0;
            out_l_ce_q    <= 1'b0;
            out_l_data_q  <= '0;
        end else if (rdy) begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            f_pend_q      <= f_pend_d;
            f_addr_q      <= f_addr_d;
            l_pend_q      <= l_pend_d;
            l_wr_q        <= l_wr_d;
            l_size_q      <= l_size_d;
            l_addr_q      <= l_addr_d;
            l_data_q      <= l_data_d;
            cur_addr_q    <= cur_addr_d;
            cur_data_q    <= cur_data_d;
            cur_n_q       <= cur_n_d;
            cur_fetch_q   <= cur_fetch_d;
            rbuf_q        <= rbuf_d;
            mem_a_q       <= mem_a_d;
            mem_dout_q    <= mem_dout_d;
            mem_wr_q      <= mem_wr_d;
            out_f_ce_q    <= out_f_ce_d;
            out_f_instr_q <= out_f_instr_d;
            out_l_ce_q    <= out_l_ce_d;
            out_l_data_q  <= out_l_data_d;
        end
    end

    assign out_fetcher_ce    = out_f_ce_q;
    assign out_fetcher_instr = out_f_instr_q;
    assign out_lsb_ce        = out_l_ce_q;
    assign out_lsb_data      = out_l_data_q;
    assign mem_a             = mem_a_q;
    assign mem_dout          = mem_dout_q;
    assign mem_wr            = mem_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed self-checking bench for mem_ctrl
module tb_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        in_fetcher_ce;
    logic [31:0] in_fetcher_pc;
    logic        out_fetcher_ce;
    logic [31:0] out_fetcher_instr;
    logic        in_lsb_ce;
    logic        in_lsb_wr;
    logic [1:0]  in_lsb_size;
    logic [31:0] in_lsb_addr;
    logic [31:0] in_lsb_data;
    logic        out_lsb_ce;
    logic [31:0] out_lsb_data;
    logic        in_rob_misbranch;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    int tests_run;
    int tests_failed;

    logic [7:0] ram [0:1023];

    mem_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .rdy               (rdy),
        .in_fetcher_ce     (in_fetcher_ce),
        .in_fetcher_pc     (in_fetcher_pc),
        .out_fetcher_ce    (out_fetcher_ce),
        .out_fetcher_instr (out_fetcher_instr),
        .in_lsb_ce         (in_lsb_ce),
        .in_lsb_wr         (in_lsb_wr),
        .in_lsb_size       (in_lsb_size),
        .in_lsb_addr       (in_lsb_addr),
        .in_lsb_data       (in_lsb_data),
        .out_lsb_ce        (out_lsb_ce),
        .out_lsb_data      (out_lsb_data),
        .in_rob_misbranch  (in_rob_misbranch),
        .mem_din           (mem_din),
        .mem_dout          (mem_dout),
        .mem_a             (mem_a),
        .mem_wr            (mem_wr),
        .io_buffer_full    (io_buffer_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_din = ram[mem_a[9:0]];
    always @(posedge clk) if (mem_wr) ram[mem_a[9:0]] <= mem_dout;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fetch_req(input logic [31:0] pc);
        in_fetcher_ce = 1'b1;
        in_fetcher_pc = pc;
        tick();
        in_fetcher_ce = 1'b0;
    endtask

    task automatic lsb_req(input logic wr, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] data);
        in_lsb_ce   = 1'b1;
        in_lsb_wr   = wr;
        in_lsb_size = size;
        in_lsb_addr = addr;
        in_lsb_data = data;
        tick();
        in_lsb_ce   = 1'b0;
    endtask

    task automatic wait_fetch(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!out_fetcher_ce && n < 20);
    endtask

    task automatic wait_lsb(output int n, output int wr_cnt);
        n = 0;
        wr_cnt = 0;
        do begin
            tick();
            n++;
            if (mem_wr) wr_cnt++;
        end while (!out_lsb_ce && n < 20);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        int n, wr_cnt, lt, ft, seen, t;
        logic [31:0] ld, fd;
        tests_run        = 0;
        tests_failed     = 0;
        rst              = 1'b0;
        rdy              = 1'b1;
        in_fetcher_ce    = 1'b0;
        in_fetcher_pc    = '0;
        in_lsb_ce        = 1'b0;
        in_lsb_wr        = 1'b0;
        in_lsb_size      = '0;
        in_lsb_addr      = '0;
        in_lsb_data      = '0;
        in_rob_misbranch = 1'b0;
        io_buffer_full   = 1'b0;
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        ram[10'h100] = 8'h13; ram[10'h101] = 8'h05; ram[10'h102] = 8'h00; ram[10'h103] = 8'h00;
        ram[10'h040] = 8'h78; ram[10'h041] = 8'h56; ram[10'h042] = 8'h34; ram[10'h043] = 8'h12;

        repeat (3) @(negedge clk);
        check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_f_ce", {31'd0, out_fetcher_ce}, 32'd0);
        check("rst_l_ce", {31'd0, out_lsb_ce}, 32'd0);
        rst = 1'b1;
        tick();

        // Fetch: pulse sampled at edge A, E0 = A+1, completion E5 = A+6.
        fetch_req(32'h100);
        wait_fetch(n);
        check("fetch_lat", n, 32'd6);
        check("fetch_instr", out_fetcher_instr, 32'h0000_0513);
        tick();
        check("fetch_ce_1cyc", {31'd0, out_fetcher_ce}, 32'd0);

        // Word store: mem_wr on E0..E3, completion on E4.
        lsb_req(1'b1, 2'd2, 32'h20, 32'hDEAD_BEEF);
        wait_lsb(n, wr_cnt);
        check("st_lat", n, 32'd5);
        check("st_wr_cycles", wr_cnt, 32'd4);
        check("st_ram", {ram[10'h023], ram[10'h022], ram[10'h021], ram[10'h020]}, 32'hDEAD_BEEF);
        check("st_data0", out_lsb_data, 32'd0);
        tick();
        lsb_req(1'b0, 2'd1, 32'h20, 32'h0);
        wait_lsb(n, wr_cnt);
        check("ldh_lat", n, 32'd4);
        check("ldh_data", out_lsb_data, 32'h0000_BEEF);
        tick();

        // Simultaneous load and fetch: load first, one IDLE cycle, then fetch.
        in_fetcher_ce = 1'b1; in_fetcher_pc = 32'h100;
        in_lsb_ce = 1'b1; in_lsb_wr = 1'b0; in_lsb_size = 2'd2; in_lsb_addr = 32'h40;
        tick();
        in_fetcher_ce = 1'b0; in_lsb_ce = 1'b0;
        lt = 0; ft = 0; ld = '0; fd = '0; t = 0;
        while (ft == 0 && t < 30) begin
            tick();
            t++;
            if (out_lsb_ce) begin lt = t; ld = out_lsb_data; end
            if (out_fetcher_ce) begin ft = t; fd = out_fetcher_instr; end
        end
        check("arb_ld_t", lt, 32'd6);
        check("arb_ld_data", ld, 32'h1234_5678);
        check("arb_f_t", ft, 32'd12);
        check("arb_f_data", fd, 32'h0000_0513);
        tick();

        // Misbranch at E2 aborts the fetch; store pulsed at E1 still completes.
        fetch_req(32'h100);
        tick();
        in_lsb_ce = 1'b1; in_lsb_wr = 1'b1; in_lsb_size = 2'd0;
        in_lsb_addr = 32'h60; in_lsb_data = 32'h0000_00A5;
        tick();
        in_lsb_ce = 1'b0;
        check("mb_wr_before", {31'd0, mem_wr}, 32'd0);
        in_rob_misbranch = 1'b1;
        tick();
        in_rob_misbranch = 1'b0;
        check("mb_wr_at_abort", {31'd0, mem_wr}, 32'd0);
        seen = 0; lt = 0; wr_cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (out_fetcher_ce) seen++;
            if (mem_wr) wr_cnt++;
            if (out_lsb_ce && lt == 0) lt = i;
        end
        check("mb_no_fetch", seen, 32'd0);
        check("mb_st_lat", lt, 32'd2);
        check("mb_st_wr_cycles", wr_cnt, 32'd1);
        check("mb_st_ram", {24'd0, ram[10'h060]}, 32'h0000_00A5);

        // Load pulse together with misbranch is dropped.
        in_lsb_ce = 1'b1; in_lsb_wr = 1'b0; in_lsb_size = 2'd2; in_lsb_addr = 32'h40;
        in_rob_misbranch = 1'b1;
        tick();
        in_lsb_ce = 1'b0; in_rob_misbranch = 1'b0;
        seen = 0;
        repeat (10) begin tick(); if (out_lsb_ce) seen++; end
        check("mb_drop_load", seen, 32'd0);

        // Asynchronous reset in the middle of a word store.
        lsb_req(1'b1, 2'd2, 32'h80, 32'h1122_3344);
        tick();
        tick();
        check("rw_wr_pre", {31'd0, mem_wr}, 32'd1);
        rst = 1'b0;
        #1;
        check("rw_wr_async", {31'd0, mem_wr}, 32'd0);
        check("rw_a_async", mem_a, 32'd0);
        check("rw_dout_async", {24'd0, mem_dout}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (3) begin tick(); if (out_lsb_ce || mem_wr) seen++; end
        check("rw_idle_after", seen, 32'd0);
        fetch_req(32'h100);
        wait_fetch(n);
        check("rw_fetch_lat", n, 32'd6);
        check("rw_fetch_instr", out_fetcher_instr, 32'h0000_0513);
        tick();

        // rdy low freezes the sequence for three edges.
        fetch_req(32'h100);
        rdy = 1'b0;
        repeat (3) tick();
        rdy = 1'b1;
        wait_fetch(n);
        check("rdy_lat", n + 3, 32'd9);
        check("rdy_instr", out_fetcher_instr, 32'h0000_0513);
        tick();

        // Byte store into the IO region with the buffer full for three edges.
        io_buffer_full = 1'b1;
        lsb_req(1'b1, 2'd0, 32'h0003_0000, 32'h0000_005A);
        n = 0; wr_cnt = 0; seen = 0;
        do begin
            tick();
            n++;
            if (mem_wr) begin
                wr_cnt++;
                if (n <= 3) seen++;
            end
            if (n == 3) io_buffer_full = 1'b0;
        end while (!out_lsb_ce && n < 20);
        io_buffer_full = 1'b0;
`ifdef IO_STALL_EN
        check("io_lat", n, 32'd5);
        check("io_held", seen, 32'd0);
`else
        check("io_lat", n, 32'd2);
        check("io_held", seen, 32'd1);
`endif
        check("io_wr_cycles", wr_cnt, 32'd1);
        check("io_ram", {24'd0, ram[10'h000]}, 32'h0000_005A);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory-side responder for the instruction-fetch request/response interface and the LSB load/store interface.
- Accepts single-cycle request pulses, latches them and arbitrates between them.
- Sequences byte-wide RAM accesses and assembles or splits 32-bit words.
- Returns a single-cycle completion pulse with data to the requester.

Parameters:
- ADDR_WIDTH, 32: width of RAM byte address and of request addresses.
- IO_ADDR_BASE, 32'h30000: lowest address treated as memory-mapped IO (used only with IO_STALL_EN).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global ready; when low, all registers hold.
- in_fetcher_ce  in  1  one-cycle instruction fetch request pulse.
- in_fetcher_pc  in  32  fetch address.
- out_fetcher_ce  out  1  one-cycle fetch completion pulse.
- out_fetcher_instr  out  32  fetched instruction, little-endian; valid while out_fetcher_ce is high.
- in_lsb_ce  in  1  one-cycle LSB request pulse.
- in_lsb_wr  in  1  1 = store, 0 = load.
- in_lsb_size  in  2  0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes; 3 is illegal (treated as 4).
- in_lsb_addr  in  32  byte address.
- in_lsb_data  in  32  store data, low bytes used.
- out_lsb_ce  out  1  one-cycle LSB completion pulse.
- out_lsb_data  out  32  load data, zero-extended; 0 for stores.
- in_rob_misbranch  in  1  flush of speculative requests.
- mem_din  in  8  RAM read byte; valid one edge after its address was presented.
- mem_dout  out  8  RAM write byte.
- mem_a  out  ADDR_WIDTH  RAM byte address.
- mem_wr  out  1  RAM write enable.
- io_buffer_full  in  1  UART FIFO full flag.

Behaviour:
Reset (rst low, asynchronous):
- All outputs 0, state IDLE, both pending latches cleared, byte counter 0.

Request latching:
- A high in_fetcher_ce or in_lsb_ce sets its pending latch together with its address, size and data, even while the block is busy.
- A new pulse overwrites the held request of the same source.

States: IDLE, READ, WRITE.
- IDLE → WRITE or READ when a request is pending. The LSB pending request has priority over fetch. A fetch is a 4-byte READ.
- On the start edge E0: mem_a ← addr, counter ← 0; for a store also mem_wr ← 1 and mem_dout ← byte 0.
- READ of N bytes:
  - Edges E1..E(N-1) present addr+1..addr+N-1.
  - Byte k is captured from mem_din at edge E(k+1).
  - At E(N+1): the completion pulse goes high, with data assembled from the captured bytes; state ← IDLE.
  - Fetch latency from acceptance is therefore 5 edges.
- WRITE of N bytes:
  - Byte k (in_lsb_data[8k+7:8k]) is driven at address addr+k on edge Ek.
  - At EN: mem_wr ← 0, out_lsb_ce ← 1, state ← IDLE.
- mem_wr is high only in WRITE.
- At least one IDLE cycle separates transactions. The pending latch of the started request is cleared on E0.
- Completion pulses are exactly one cycle wide. out_*_ce is never high for two consecutive cycles.

Misbranch (in_rob_misbranch high at an edge):
- Clears the fetch pending latch and any pending load.
- Aborts a READ in progress: state ← IDLE, no completion pulse.
- A store that is pending or in progress is unaffected and completes normally.
- A request pulse arriving on the same edge as misbranch is dropped, unless it is a store.

Address arithmetic:
- Modulo 2^ADDR_WIDTH; wrap past all-ones is allowed.

Optional Feature:
- Macro IO_STALL_EN.
- Defined: before driving any store byte whose address is ≥ IO_ADDR_BASE, if io_buffer_full is high, hold. mem_wr = 0 and counter and address are unchanged until the flag drops; the byte then proceeds and completion is delayed accordingly.
- Undefined: io_buffer_full is ignored.

Decomposition:
- Add to the shared constant header: size encodings MEM_SIZE_B/H/W, state encodings, IO_ADDR_BASE default.
- No sub-module; a single FSM with a byte counter.

Test Plan:
- Fetch at 0x100 with RAM bytes 13 05 00 00 → out_fetcher_ce pulses 5 edges after acceptance, out_fetcher_instr = 0x00000513.
- Store word 0xDEADBEEF to 0x20 → mem_wr high for 4 edges with bytes EF BE AD DE at 0x20..0x23; out_lsb_ce on the 4th edge; then reading 0x20 size 2 returns 0x0000BEEF.
- Fetch and LSB load pulses in the same cycle → load serviced first; fetch starts one IDLE cycle after out_lsb_ce; both return correct data.
- Misbranch 2 edges into a fetch → no out_fetcher_ce, mem_wr stays 0; a store issued mid-fetch still completes.
- rst pulsed low mid-WRITE → outputs 0 immediately with no clock; after release the state is IDLE and a new fetch completes normally.
- IO_STALL_EN defined: 1-byte store to 0x30000 while io_buffer_full = 1 for 3 cycles → mem_wr is held 0 for those cycles, then the byte is written and out_lsb_ce follows.
